// File: rtl/dma_fifo_addr_ctrl_if.sv
// Command/status bundle between the DMA address controller and the MIG command FIFOs.
// The master side is the controller; the slave side is the environment.
interface dma_fifo_addr_ctrl_if #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned CNT_W  = 5
);
  logic              I_calib_done;
  logic              I_wr_beat;
  logic              I_rd_start;
  logic              I_wr_cmd_full;
  logic              I_rd_cmd_full;
  logic              O_wr_cmd_wren;
  logic [2:0]        O_wr_cmd_wrcmd;
  logic [7:0]        O_wr_cmd_wrbl;
  logic [ADDR_W-1:0] O_wr_cmd_wraddr;
  logic              O_rd_cmd_wren;
  logic [2:0]        O_rd_cmd_wrcmd;
  logic [7:0]        O_rd_cmd_wrbl;
  logic [ADDR_W-1:0] O_rd_cmd_wraddr;
  logic [CNT_W-1:0]  O_burst_cnt;
  logic              O_overflow;

  modport master (
    input  I_calib_done, I_wr_beat, I_rd_start, I_wr_cmd_full, I_rd_cmd_full,
    output O_wr_cmd_wren, O_wr_cmd_wrcmd, O_wr_cmd_wrbl, O_wr_cmd_wraddr,
    output O_rd_cmd_wren, O_rd_cmd_wrcmd, O_rd_cmd_wrbl, O_rd_cmd_wraddr,
    output O_burst_cnt, O_overflow
  );

  modport slave (
    output I_calib_done, I_wr_beat, I_rd_start, I_wr_cmd_full, I_rd_cmd_full,
    input  O_wr_cmd_wren, O_wr_cmd_wrcmd, O_wr_cmd_wrbl, O_wr_cmd_wraddr,
    input  O_rd_cmd_wren, O_rd_cmd_wrcmd, O_rd_cmd_wrbl, O_rd_cmd_wraddr,
    input  O_burst_cnt, O_overflow
  );
endinterface

// File: rtl/dma_fifo_addr_ctrl.sv
// DDR3 DMA command/address generator: one write command per completed burst of beats,
// one read command per request, over a ring of NUM_BURST bursts.
module dma_fifo_addr_ctrl #(
  parameter int unsigned       ADDR_W    = 28,
  parameter int unsigned       BL        = 64,
  parameter int unsigned       ADDR_STEP = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       NUM_BURST = 16
) (
  input logic                  I_Clk,
  input logic                  I_Rst,
  dma_fifo_addr_ctrl_if.master bus
);

    localparam int unsigned CNT_W  = $clog2(NUM_BURST) + 1;
    localparam int unsigned BEAT_W = (BL > 1) ? $clog2(BL) : 1;
    localparam logic [ADDR_W:0] STEP     = (ADDR_W+1)'(BL * ADDR_STEP);
    localparam logic [ADDR_W:0] RING_END = {1'b0, BASE_ADDR} + (ADDR_W+1)'(NUM_BURST * BL * ADDR_STEP);

    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [7:0]        wr_pend_q, wr_pend_d;
    logic [3:0]        rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic              overflow_q, overflow_d;
    logic              wr_wren_q, wr_wren_d, rd_wren_q, rd_wren_d;
    logic              beat_last, wr_issue, rd_issue, overwrite;

    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        logic [ADDR_W:0] s;
        s = {1'b0, p} + STEP;
        return (s >= RING_END) ? BASE_ADDR : s[ADDR_W-1:0];
    endfunction

    always_comb begin
        beat_last = bus.I_wr_beat && (beat_cnt_q == BEAT_W'(BL - 1));
        wr_issue  = (wr_pend_q != '0) && bus.I_calib_done && !bus.I_wr_cmd_full;
        rd_issue  = (rd_pend_q != '0) && (burst_cnt_q != '0) && bus.I_calib_done && !bus.I_rd_cmd_full;
        overwrite = wr_issue && (burst_cnt_q == CNT_W'(NUM_BURST));

        beat_cnt_d = beat_cnt_q;
        if (bus.I_wr_beat) beat_cnt_d = beat_last ? '0 : beat_cnt_q + 1'b1;

        wr_pend_d = wr_pend_q;
        unique case ({beat_last, wr_issue})
            2'b10:   if (wr_pend_q != '1) wr_pend_d = wr_pend_q + 1'b1;
            2'b01:   wr_pend_d = wr_pend_q - 1'b1;
            default: wr_pend_d = wr_pend_q;
        endcase

        rd_pend_d = rd_pend_q;
        unique case ({bus.I_rd_start, rd_issue})
            2'b10:   if (rd_pend_q != '1) rd_pend_d = rd_pend_q + 1'b1;
            2'b01:   rd_pend_d = rd_pend_q - 1'b1;
            default: rd_pend_d = rd_pend_q;
        endcase

        // An overwrite of the oldest burst retires it, so the read pointer skips past it
        // on top of any read issued in the same cycle.
        wr_ptr_d = wr_issue ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (rd_issue)  rd_ptr_d = ptr_inc(rd_ptr_d);
        if (overwrite) rd_ptr_d = ptr_inc(rd_ptr_d);

        burst_cnt_d = burst_cnt_q;
        if (wr_issue && !overwrite) burst_cnt_d = burst_cnt_d + 1'b1;
        if (rd_issue)               burst_cnt_d = burst_cnt_d - 1'b1;

        overflow_d = overflow_q | overwrite;
        wr_wren_d  = wr_issue;
        rd_wren_d  = rd_issue;
        wr_addr_d  = wr_issue ? wr_ptr_q : wr_addr_q;
        rd_addr_d  = rd_issue ? rd_ptr_q : rd_addr_q;
    end

    always_ff @(posedge I_Clk or posedge I_Rst) begin
        if (I_Rst) begin
            beat_cnt_q  <= '0;
            wr_pend_q   <= '0;
            rd_pend_q   <= '0;
            wr_ptr_q    <= BASE_ADDR;
            rd_ptr_q    <= BASE_ADDR;
            wr_addr_q   <= BASE_ADDR;
            rd_addr_q   <= BASE_ADDR;
            burst_cnt_q <= '0;
            overflow_q  <= 1'b0;
            wr_wren_q   <= 1'b0;
            rd_wren_q   <= 1'b0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            wr_pend_q   <= wr_pend_d;
            rd_pend_q   <= rd_pend_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            burst_cnt_q <= burst_cnt_d;
            overflow_q  <= overflow_d;
            wr_wren_q   <= wr_wren_d;
            rd_wren_q   <= rd_wren_d;
        end
    end

    assign bus.O_wr_cmd_wren   = wr_wren_q;
    assign bus.O_wr_cmd_wrcmd  = 3'b000;
    assign bus.O_wr_cmd_wrbl   = 8'(BL);
    assign bus.O_wr_cmd_wraddr = wr_addr_q;
    assign bus.O_rd_cmd_wren   = rd_wren_q;
    assign bus.O_rd_cmd_wrcmd  = 3'b001;
    assign bus.O_rd_cmd_wrbl   = 8'(BL);
    assign bus.O_rd_cmd_wraddr = rd_addr_q;
    assign bus.O_burst_cnt     = burst_cnt_q;
    assign bus.O_overflow      = overflow_q;

endmodule

// File: tb/tb_dma_fifo_addr_ctrl.sv
// Directed bench for dma_fifo_addr_ctrl: strobes are logged by a monitor and checked
// against hand-computed addresses, latencies and counters.
module tb_dma_fifo_addr_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dma_fifo_addr_ctrl_if #(.ADDR_W(28), .CNT_W(5)) bus ();

    dma_fifo_addr_ctrl #(
        .ADDR_W(28), .BL(64), .ADDR_STEP(8), .BASE_ADDR(28'h0), .NUM_BURST(16)
    ) dut (
        .I_Clk(clk),
        .I_Rst(rst),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int field_bad = 0;
    int t_mark;
    logic [27:0] wr_q[$];
    logic [27:0] rd_q[$];
    int wr_t[$];
    int rd_t[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.O_wr_cmd_wren === 1'b1) begin
            wr_q.push_back(bus.O_wr_cmd_wraddr);
            wr_t.push_back(cyc);
            if (bus.O_wr_cmd_wrcmd !== 3'b000 || bus.O_wr_cmd_wrbl !== 8'd64) field_bad++;
        end
        if (bus.O_rd_cmd_wren === 1'b1) begin
            rd_q.push_back(bus.O_rd_cmd_wraddr);
            rd_t.push_back(cyc);
            if (bus.O_rd_cmd_wrcmd !== 3'b001 || bus.O_rd_cmd_wrbl !== 8'd64) field_bad++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic beats(input int n);
        bus.I_wr_beat = 1'b1;
        repeat (n) tick();
        bus.I_wr_beat = 1'b0;
    endtask

    task automatic clearq();
        wr_q.delete();
        rd_q.delete();
        wr_t.delete();
        rd_t.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.I_wr_beat     = 1'b0;
        bus.I_rd_start    = 1'b0;
        bus.I_wr_cmd_full = 1'b0;
        bus.I_rd_cmd_full = 1'b0;
        bus.I_calib_done  = 1'b1;
        ticks(2);
        rst = 1'b0;
        tick();
        clearq();
    endtask

    initial begin
        bus.I_calib_done  = 1'b1;
        bus.I_wr_beat     = 1'b0;
        bus.I_rd_start    = 1'b0;
        bus.I_wr_cmd_full = 1'b0;
        bus.I_rd_cmd_full = 1'b0;
        ticks(2);

        check("rst_wr_wren",  bus.O_wr_cmd_wren, 0);
        check("rst_rd_wren",  bus.O_rd_cmd_wren, 0);
        check("rst_wraddr",   bus.O_wr_cmd_wraddr, 0);
        check("rst_rdaddr",   bus.O_rd_cmd_wraddr, 0);
        check("rst_burst",    bus.O_burst_cnt, 0);
        check("rst_overflow", bus.O_overflow, 0);
        check("rst_wrcmd",    bus.O_wr_cmd_wrcmd, 0);
        check("rst_rdcmd",    bus.O_rd_cmd_wrcmd, 1);
        check("rst_wrbl",     bus.O_wr_cmd_wrbl, 64);
        check("rst_rdbl",     bus.O_rd_cmd_wrbl, 64);
        rst = 1'b0;
        tick();
        clearq();

        // Single burst: strobe lands one edge after the edge sampling the final beat.
        beats(64);
        check("A_wren_early", bus.O_wr_cmd_wren, 0);
        tick();
        check("A_wren",       bus.O_wr_cmd_wren, 1);
        check("A_wraddr",     bus.O_wr_cmd_wraddr, 28'h000);
        check("A_burst",      bus.O_burst_cnt, 1);
        tick();
        check("A_wren_pulse", bus.O_wr_cmd_wren, 0);
        check("A_nstrobe",    wr_q.size(), 1);

        // Two bursts, then two reads on alternate cycles.
        do_reset();
        beats(128);
        ticks(4);
        check("B_nwr",   wr_q.size(), 2);
        check("B_wr0",   wr_q[0], 28'h000);
        check("B_wr1",   wr_q[1], 28'h200);
        check("B_burst", bus.O_burst_cnt, 2);
        bus.I_rd_start = 1'b1;
        tick();
        t_mark = cyc;
        bus.I_rd_start = 1'b0;
        tick();
        bus.I_rd_start = 1'b1;
        tick();
        bus.I_rd_start = 1'b0;
        ticks(4);
        check("B_nrd",     rd_q.size(), 2);
        check("B_rd0",     rd_q[0], 28'h000);
        check("B_rd1",     rd_q[1], 28'h200);
        check("B_rd_lat",  rd_t[0], t_mark + 1);
        check("B_burst0",  bus.O_burst_cnt, 0);

        // Read request on an empty ring waits for the next burst.
        clearq();
        bus.I_rd_start = 1'b1;
        tick();
        bus.I_rd_start = 1'b0;
        ticks(6);
        check("C_nrd_wait", rd_q.size(), 0);
        beats(64);
        ticks(4);
        check("C_nwr",   wr_q.size(), 1);
        check("C_wr0",   wr_q[0], 28'h400);
        check("C_nrd",   rd_q.size(), 1);
        check("C_rd0",   rd_q[0], 28'h400);
        check("C_burst", bus.O_burst_cnt, 0);

        // Command FIFO full: both bursts held, then issued on consecutive cycles.
        do_reset();
        bus.I_wr_cmd_full = 1'b1;
        beats(128);
        ticks(5);
        check("D_nwr_held",  wr_q.size(), 0);
        check("D_burst_hld", bus.O_burst_cnt, 0);
        bus.I_wr_cmd_full = 1'b0;
        ticks(4);
        check("D_nwr",   wr_q.size(), 2);
        check("D_wr0",   wr_q[0], 28'h000);
        check("D_wr1",   wr_q[1], 28'h200);
        check("D_b2b",   wr_t[1] - wr_t[0], 1);
        check("D_burst", bus.O_burst_cnt, 2);

        // Calibration not done: beats counted, command held.
        do_reset();
        bus.I_calib_done = 1'b0;
        beats(64);
        ticks(5);
        check("E_nwr_nocal", wr_q.size(), 0);
        bus.I_calib_done = 1'b1;
        ticks(3);
        check("E_nwr", wr_q.size(), 1);
        check("E_wr0", wr_q[0], 28'h000);

        // Asynchronous reset right before the strobe would appear.
        do_reset();
        beats(64);
        #2 rst = 1'b1;
        #1;
        check("F_wren_rst",  bus.O_wr_cmd_wren, 0);
        check("F_burst_rst", bus.O_burst_cnt, 0);
        tick();
        rst = 1'b0;
        ticks(4);
        check("F_nwr", wr_q.size(), 0);

        // Fill the ring, then overflow with a 17th burst.
        do_reset();
        beats(16 * 64);
        ticks(3);
        check("G_nwr16",  wr_q.size(), 16);
        check("G_wr15",   wr_q[15], 28'h1E00);
        check("G_burst16", bus.O_burst_cnt, 16);
        check("G_ovf0",   bus.O_overflow, 0);
        beats(64);
        ticks(3);
        check("G_nwr17",  wr_q.size(), 17);
        check("G_wr16",   wr_q[16], 28'h0000);
        check("G_ovf1",   bus.O_overflow, 1);
        check("G_burst_k", bus.O_burst_cnt, 16);
        bus.I_rd_start = 1'b1;
        tick();
        bus.I_rd_start = 1'b0;
        ticks(4);
        check("G_nrd",    rd_q.size(), 1);
        check("G_rd0",    rd_q[0], 28'h200);
        check("G_burst15", bus.O_burst_cnt, 15);

        check("fields", field_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
